// File: rtl/graphics_op_pkg.sv
// Shared definitions for the graphics-op execute sequencer: opcode values
// (identical to the processor decode's FUNCTION_* constants), FSM states, collision kinds.
package graphics_op_pkg;

  localparam logic [4:0] FUNCTION_SPRITE_LEVEL        = 5'b00001;
  localparam logic [4:0] FUNCTION_SPRITE_POS          = 5'b00010;
  localparam logic [4:0] FUNCTION_SPRITE_COLLISION_BG = 5'b00011;
  localparam logic [4:0] FUNCTION_SPRITE_COLLISION_SP = 5'b00100;
  localparam logic [4:0] FUNCTION_PUT_IMAGE           = 5'b00101;
  localparam logic [4:0] FUNCTION_WAIT_VSYNC          = 5'b00110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_VS  = 2'd1,
    ST_IMG_WAIT = 2'd2,
    ST_COL_WAIT = 2'd3
  } state_t;

  localparam logic COL_KIND_BG = 1'b0;
  localparam logic COL_KIND_SP = 1'b1;

endpackage

// File: rtl/graphics_op_controller_handshake_timer.sv
// Waiting-cycle counter for req/ack handshakes; o_expire flags the last allowed
// waiting cycle. ACK_TIMEOUT == 0 never expires.
module handshake_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_expire  = (ACK_TIMEOUT > 0) && i_enable && w_at_last;

  // Saturates at LAST so a disabled timeout never wraps into a false expiry.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/graphics_op_controller.sv
// Execute-stage sequencer for graphics ops: single-cycle register writes in IDLE,
// PC stall while waiting for VSYNC or for the image writer / collision unit acks.
module graphics_op_controller
  import graphics_op_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   op_valid,
  input  logic [4:0]             op_code,
  input  logic [4:0]             op_sprite_id,
  input  logic [COORD_WIDTH-1:0] op_x,
  input  logic [COORD_WIDTH-1:0] op_y,
  output logic                   op_ready,
  input  logic                   vsync,
  output logic                   img_req,
  input  logic                   img_ack,
  output logic [COORD_WIDTH-1:0] img_x,
  output logic [COORD_WIDTH-1:0] img_y,
  output logic                   col_req,
  output logic                   col_kind,
  output logic [4:0]             col_sprite_id,
  input  logic                   col_ack,
  input  logic                   col_hit,
  output logic [COORD_WIDTH-1:0] background_x,
  output logic [COORD_WIDTH-1:0] background_y,
  output logic [COORD_WIDTH-1:0] sprite_x,
  output logic [COORD_WIDTH-1:0] sprite_y,
  output logic [4:0]             sprite_id,
  output logic [4:0]             sprite_level,
  output logic                   sprite_we,
  output logic                   level_we,
  output logic                   result_valid,
  output logic                   result,
  output logic                   timeout
);

  state_t r_state, w_state_nxt;
  logic   r_vsync_q;
  logic   w_vsync_edge, w_expire, w_waiting;
  logic   w_pos, w_lvl, w_img_start, w_col_start;
  logic   w_img_done, w_img_tmo, w_col_done, w_col_tmo;

  logic                   r_img_req, r_col_req, r_col_kind;
  logic [COORD_WIDTH-1:0] r_img_x, r_img_y, r_bg_x, r_bg_y, r_sprite_x, r_sprite_y;
  logic [4:0]             r_col_sprite_id, r_sprite_id, r_sprite_level;
  logic                   r_sprite_we, r_level_we, r_result_valid, r_result, r_timeout;

  assign op_ready     = (r_state == ST_IDLE);
  assign w_vsync_edge = vsync & ~r_vsync_q;
  assign w_waiting    = (r_state == ST_IMG_WAIT) || (r_state == ST_COL_WAIT);

  handshake_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_img_start | w_col_start),
    .i_enable (w_waiting),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_vsync_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_q <= vsync;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos       = 1'b0;
    w_lvl       = 1'b0;
    w_img_start = 1'b0;
    w_col_start = 1'b0;
    w_img_done  = 1'b0;
    w_img_tmo   = 1'b0;
    w_col_done  = 1'b0;
    w_col_tmo   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            FUNCTION_SPRITE_POS:   w_pos = 1'b1;
            FUNCTION_SPRITE_LEVEL: w_lvl = 1'b1;
            FUNCTION_PUT_IMAGE: begin
              w_img_start = 1'b1;
              w_state_nxt = ST_IMG_WAIT;
            end
            FUNCTION_SPRITE_COLLISION_BG, FUNCTION_SPRITE_COLLISION_SP: begin
              w_col_start = 1'b1;
              w_state_nxt = ST_COL_WAIT;
            end
            FUNCTION_WAIT_VSYNC:   w_state_nxt = ST_WAIT_VS;
            default: ;
          endcase
        end
      end
      ST_WAIT_VS: begin
        if (w_vsync_edge) w_state_nxt = ST_IDLE;
      end
      // An ack sampled on the expiry cycle takes priority over the timeout.
      ST_IMG_WAIT: begin
        if (img_ack) begin
          w_img_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_img_tmo   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COL_WAIT: begin
        if (col_ack) begin
          w_col_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_col_tmo   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_img_req       <= 1'b0;
      r_img_x         <= '0;
      r_img_y         <= '0;
      r_col_req       <= 1'b0;
      r_col_kind      <= COL_KIND_BG;
      r_col_sprite_id <= '0;
      r_bg_x          <= '0;
      r_bg_y          <= '0;
      r_sprite_x      <= '0;
      r_sprite_y      <= '0;
      r_sprite_id     <= '0;
      r_sprite_level  <= '0;
      r_sprite_we     <= 1'b0;
      r_level_we      <= 1'b0;
      r_result_valid  <= 1'b0;
      r_result        <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_sprite_we    <= w_pos;
      r_level_we     <= w_lvl;
      r_result_valid <= w_col_done | w_col_tmo;
      r_timeout      <= w_img_tmo | w_col_tmo;
      if (w_pos) begin
        r_sprite_x  <= op_x;
        r_sprite_y  <= op_y;
        r_sprite_id <= op_sprite_id;
      end
      if (w_lvl) begin
        r_sprite_id    <= op_sprite_id;
        r_sprite_level <= op_x[4:0];
      end
      if (w_img_start) begin
        r_img_x   <= op_x;
        r_img_y   <= op_y;
        r_img_req <= 1'b1;
      end else if (w_img_done || w_img_tmo) begin
        r_img_req <= 1'b0;
      end
      if (w_img_done) begin
        r_bg_x <= r_img_x;
        r_bg_y <= r_img_y;
      end
      if (w_col_start) begin
        r_col_kind      <= (op_code == FUNCTION_SPRITE_COLLISION_SP) ? COL_KIND_SP : COL_KIND_BG;
        r_col_sprite_id <= op_sprite_id;
        r_col_req       <= 1'b1;
      end else if (w_col_done || w_col_tmo) begin
        r_col_req <= 1'b0;
      end
      if (w_col_done) begin
        r_result <= col_hit;
      end else if (w_col_tmo) begin
        r_result <= 1'b0;
      end
    end
  end

  assign img_req       = r_img_req;
  assign img_x         = r_img_x;
  assign img_y         = r_img_y;
  assign col_req       = r_col_req;
  assign col_kind      = r_col_kind;
  assign col_sprite_id = r_col_sprite_id;
  assign background_x  = r_bg_x;
  assign background_y  = r_bg_y;
  assign sprite_x      = r_sprite_x;
  assign sprite_y      = r_sprite_y;
  assign sprite_id     = r_sprite_id;
  assign sprite_level  = r_sprite_level;
  assign sprite_we     = r_sprite_we;
  assign level_we      = r_level_we;
  assign result_valid  = r_result_valid;
  assign result        = r_result;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_graphics_op_controller.sv
// Randomized bench for graphics_op_controller: expected register contents, pulses
// and stall cycles come from a transaction-level model of the op rules.
module tb_graphics_op_controller;

  localparam int TMO = 8;
  localparam int CW  = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic [4:0]    op_code = '0;
  logic [4:0]    op_sprite_id = '0;
  logic [CW-1:0] op_x = '0;
  logic [CW-1:0] op_y = '0;
  logic          op_ready;
  logic          vsync = 1'b0;
  logic          img_req;
  logic          img_ack = 1'b0;
  logic [CW-1:0] img_x, img_y;
  logic          col_req, col_kind;
  logic [4:0]    col_sprite_id;
  logic          col_ack = 1'b0;
  logic          col_hit = 1'b0;
  logic [CW-1:0] background_x, background_y, sprite_x, sprite_y;
  logic [4:0]    sprite_id, sprite_level;
  logic          sprite_we, level_we, result_valid, result, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the visible registers must hold.
  logic [CW-1:0] m_sx, m_sy, m_bgx, m_bgy;
  logic [4:0]    m_sid, m_lvl;
  logic          m_res;

  graphics_op_controller #(.ACK_TIMEOUT(TMO), .COORD_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_sprite_id(op_sprite_id), .op_x(op_x), .op_y(op_y), .op_ready(op_ready),
    .vsync(vsync), .img_req(img_req), .img_ack(img_ack), .img_x(img_x), .img_y(img_y),
    .col_req(col_req), .col_kind(col_kind), .col_sprite_id(col_sprite_id),
    .col_ack(col_ack), .col_hit(col_hit), .background_x(background_x),
    .background_y(background_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_id(sprite_id), .sprite_level(sprite_level), .sprite_we(sprite_we),
    .level_we(level_we), .result_valid(result_valid), .result(result), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_sx = '0; m_sy = '0; m_bgx = '0; m_bgy = '0; m_sid = '0; m_lvl = '0; m_res = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    model_reset();
    n_cmp++;
    if ({img_req, img_x, img_y, col_req, col_kind, col_sprite_id, background_x, background_y,
         sprite_x, sprite_y, sprite_id, sprite_level, sprite_we, level_we, result_valid,
         result, timeout} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero (img_req=%b col_req=%b bg=%0d sx=%0d)",
                        img_req, col_req, background_x, sprite_x);
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_op_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_sprite_ops();
    logic ewe, elw;
    // Directed: position then level on consecutive cycles.
    op_valid = 1'b1; op_code = 5'd2; op_sprite_id = 5'd3; op_x = 10'd100; op_y = 10'd50;
    tick();
    op_code = 5'd1; op_sprite_id = 5'd3; op_x = 10'd7; op_y = 10'd0;
    n_cmp++;
    if ({sprite_we, level_we, sprite_x, sprite_y, sprite_id, op_ready} !== {1'b1, 1'b0, 10'd100, 10'd50, 5'd3, 1'b1}) begin
      n_bad++; $display("FAIL sprite_pos: we=%b lwe=%b x=%0d y=%0d id=%0d rdy=%b want 1 0 100 50 3 1",
                        sprite_we, level_we, sprite_x, sprite_y, sprite_id, op_ready);
    end
    tick();
    op_valid = 1'b0;
    n_cmp++;
    if ({sprite_we, level_we, sprite_level, sprite_id, sprite_x, op_ready} !== {1'b0, 1'b1, 5'd7, 5'd3, 10'd100, 1'b1}) begin
      n_bad++; $display("FAIL sprite_level: we=%b lwe=%b lvl=%0d id=%0d x=%0d rdy=%b want 0 1 7 3 100 1",
                        sprite_we, level_we, sprite_level, sprite_id, sprite_x, op_ready);
    end
    m_sx = 10'd100; m_sy = 10'd50; m_sid = 5'd3; m_lvl = 5'd7;
    tick();
    n_cmp++;
    if ({sprite_we, level_we} !== 2'b00) begin
      n_bad++; $display("FAIL pulse_stretch: we=%b lwe=%b want 0 0", sprite_we, level_we);
    end
    // Random mix of position, level and NOP codes, with idle gaps.
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      op_valid     = ($urandom_range(0, 3) != 0);
      op_code      = (sel == 0) ? 5'd2 : (sel == 1) ? 5'd1 :
                     (($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(7, 31)));
      op_sprite_id = 5'($urandom);
      op_x         = 10'($urandom);
      op_y         = 10'($urandom);
      ewe = op_valid && (op_code == 5'd2);
      elw = op_valid && (op_code == 5'd1);
      if (ewe) begin m_sx = op_x; m_sy = op_y; m_sid = op_sprite_id; end
      if (elw) begin m_sid = op_sprite_id; m_lvl = op_x[4:0]; end
      tick();
      n_cmp++;
      if ({sprite_we, level_we} !== {ewe, elw}) begin
        n_bad++; $display("FAIL rand_pulses[%0d]: we=%b lwe=%b want %b %b", i, sprite_we, level_we, ewe, elw);
      end
      n_cmp++;
      if ({sprite_x, sprite_y, sprite_id, sprite_level} !== {m_sx, m_sy, m_sid, m_lvl}) begin
        n_bad++; $display("FAIL rand_regs[%0d]: x=%0d y=%0d id=%0d lvl=%0d want %0d %0d %0d %0d", i,
                          sprite_x, sprite_y, sprite_id, sprite_level, m_sx, m_sy, m_sid, m_lvl);
      end
      n_cmp++;
      if ({op_ready, img_req, col_req} !== 3'b100) begin
        n_bad++; $display("FAIL rand_ready[%0d]: rdy/img_req/col_req=%b want 100", i, {op_ready, img_req, col_req});
      end
    end
    op_valid = 1'b0;
    tick();
  endtask

  task automatic test_wait_vsync();
    // Vsync already high at accept, then a random-length low period.
    for (int r = 0; r < 3; r++) begin
      int lo;
      lo = (r == 0) ? 5 : int'($urandom_range(1, 7));
      vsync = 1'b1;
      tick();
      op_valid = 1'b1; op_code = 5'd6;
      tick();
      // Ops presented while stalled must not be taken.
      op_code = 5'd2; op_x = 10'($urandom);
      n_cmp++;
      if (op_ready !== 1'b0) begin n_bad++; $display("FAIL vs_stall_accept[%0d]: rdy=%b want 0", r, op_ready); end
      vsync = 1'b0;
      for (int k = 0; k < lo; k++) begin
        tick();
        n_cmp++;
        if ({op_ready, sprite_we} !== 2'b00) begin
          n_bad++; $display("FAIL vs_stall_low[%0d.%0d]: rdy=%b we=%b want 0 0", r, k, op_ready, sprite_we);
        end
      end
      op_valid = 1'b0;
      vsync = 1'b1;
      n_cmp++;
      if (op_ready !== 1'b0) begin n_bad++; $display("FAIL vs_edge_cycle[%0d]: rdy=%b want 0", r, op_ready); end
      tick();
      n_cmp++;
      if (op_ready !== 1'b1) begin n_bad++; $display("FAIL vs_release[%0d]: rdy=%b want 1", r, op_ready); end
    end
    // A rising edge in the accept cycle itself is not the awaited edge.
    vsync = 1'b0;
    tick();
    op_valid = 1'b1; op_code = 5'd6; vsync = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (op_ready !== 1'b0) begin n_bad++; $display("FAIL vs_accept_edge[%0d]: rdy=%b want 0", k, op_ready); end
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL vs_accept_edge_release: rdy=%b want 1", op_ready); end
    vsync = 1'b0;
    tick();
  endtask

  // Ack arrives in waiting cycle d (1-based); d > TMO means never.
  task automatic run_img(input logic [CW-1:0] x, input logic [CW-1:0] y, input int d, input bit early);
    op_valid = 1'b1; op_code = 5'd5; op_x = x; op_y = y; img_ack = early;
    tick();
    op_valid = 1'b0; img_ack = 1'b0;
    n_cmp++;
    if ({img_req, img_x, img_y, op_ready} !== {1'b1, x, y, 1'b0}) begin
      n_bad++; $display("FAIL img_start: req=%b x=%0d y=%0d rdy=%b want 1 %0d %0d 0", img_req, img_x, img_y, op_ready, x, y);
    end
    for (int k = 1; k <= TMO; k++) begin
      if (k > 1) begin
        n_cmp++;
        if ({img_req, op_ready} !== 2'b10) begin
          n_bad++; $display("FAIL img_wait[%0d]: req=%b rdy=%b want 1 0", k, img_req, op_ready);
        end
      end
      img_ack = (k == d);
      tick();
      img_ack = 1'b0;
      if (k == d) begin
        m_bgx = x; m_bgy = y;
        n_cmp++;
        if ({img_req, timeout, op_ready, background_x, background_y} !== {1'b0, 1'b0, 1'b1, m_bgx, m_bgy}) begin
          n_bad++; $display("FAIL img_done(d=%0d): req=%b tmo=%b rdy=%b bg=%0d,%0d want 0 0 1 %0d,%0d",
                            d, img_req, timeout, op_ready, background_x, background_y, m_bgx, m_bgy);
        end
        break;
      end else if (k == TMO) begin
        n_cmp++;
        if ({img_req, timeout, op_ready, background_x, background_y} !== {1'b0, 1'b1, 1'b1, m_bgx, m_bgy}) begin
          n_bad++; $display("FAIL img_timeout: req=%b tmo=%b rdy=%b bg=%0d,%0d want 0 1 1 %0d,%0d",
                            img_req, timeout, op_ready, background_x, background_y, m_bgx, m_bgy);
        end
      end
    end
    tick();
    n_cmp++;
    if ({timeout, result_valid, img_req, background_x, background_y} !== {1'b0, 1'b0, 1'b0, m_bgx, m_bgy}) begin
      n_bad++; $display("FAIL img_after: tmo=%b rv=%b req=%b bg=%0d,%0d want 0 0 0 %0d,%0d",
                        timeout, result_valid, img_req, background_x, background_y, m_bgx, m_bgy);
    end
  endtask

  task automatic test_put_image();
    run_img(10'd320, 10'd240, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_img(10'($urandom), 10'($urandom), int'($urandom_range(1, TMO + 3)), 1'b0);
    end
  endtask

  task automatic run_col(input bit kind, input logic [4:0] id, input bit hit, input int d);
    op_valid = 1'b1; op_code = kind ? 5'd4 : 5'd3; op_sprite_id = id;
    tick();
    op_valid = 1'b0;
    n_cmp++;
    if ({col_req, col_kind, col_sprite_id, op_ready, result_valid} !== {1'b1, kind, id, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL col_start: req=%b kind=%b id=%0d rdy=%b rv=%b want 1 %b %0d 0 0",
                        col_req, col_kind, col_sprite_id, op_ready, result_valid, kind, id);
    end
    for (int k = 1; k <= TMO; k++) begin
      if (k > 1) begin
        n_cmp++;
        if ({col_req, op_ready, result_valid} !== 3'b100) begin
          n_bad++; $display("FAIL col_wait[%0d]: req=%b rdy=%b rv=%b want 1 0 0", k, col_req, op_ready, result_valid);
        end
      end
      col_ack = (k == d);
      col_hit = (k == d) ? hit : 1'($urandom);
      tick();
      col_ack = 1'b0;
      if (k == d) begin
        m_res = hit;
        n_cmp++;
        if ({col_req, result_valid, result, timeout, op_ready} !== {1'b0, 1'b1, m_res, 1'b0, 1'b1}) begin
          n_bad++; $display("FAIL col_done(d=%0d): req=%b rv=%b res=%b tmo=%b rdy=%b want 0 1 %b 0 1",
                            d, col_req, result_valid, result, timeout, op_ready, m_res);
        end
        break;
      end else if (k == TMO) begin
        m_res = 1'b0;
        n_cmp++;
        if ({col_req, result_valid, result, timeout, op_ready} !== 5'b01011) begin
          n_bad++; $display("FAIL col_timeout: req=%b rv=%b res=%b tmo=%b rdy=%b want 0 1 0 1 1",
                            col_req, result_valid, result, timeout, op_ready);
        end
      end
    end
    tick();
    n_cmp++;
    if ({result_valid, timeout, result, col_req} !== {1'b0, 1'b0, m_res, 1'b0}) begin
      n_bad++; $display("FAIL col_after: rv=%b tmo=%b res=%b req=%b want 0 0 %b 0",
                        result_valid, timeout, result, col_req, m_res);
    end
  endtask

  task automatic test_collision();
    run_col(1'b1, 5'd9, 1'b1, 2);
    run_col(1'b0, 5'd5, 1'b1, TMO + 10);
    run_col(1'b0, 5'd12, 1'b1, TMO);
    for (int i = 0; i < 5; i++) begin
      run_col(1'($urandom), 5'($urandom), 1'($urandom), int'($urandom_range(1, TMO + 3)));
    end
  endtask

  task automatic test_reset_mid_op();
    logic [CW-1:0] rx, ry;
    rx = 10'($urandom); ry = 10'($urandom);
    op_valid = 1'b1; op_code = 5'd5; op_x = rx; op_y = ry;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if ({img_req, img_x, img_y, col_req, col_kind, col_sprite_id, background_x, background_y,
         sprite_x, sprite_y, sprite_id, sprite_level, sprite_we, level_we, result_valid,
         result, timeout} !== '0) begin
      n_bad++; $display("FAIL mid_img_reset: img_req=%b bg=%0d,%0d sx=%0d res=%b want all 0",
                        img_req, background_x, background_y, sprite_x, result);
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL mid_img_reset_ready: rdy=%b want 1", op_ready); end
    // Collision aborted by reset: no late result or timeout pulse.
    op_valid = 1'b1; op_code = 5'd3; op_sprite_id = 5'($urandom);
    tick();
    op_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < TMO + 3; k++) begin
      n_cmp++;
      if ({col_req, result_valid, timeout, op_ready} !== 4'b0001) begin
        n_bad++; $display("FAIL mid_col_reset[%0d]: req=%b rv=%b tmo=%b rdy=%b want 0 0 0 1",
                          k, col_req, result_valid, timeout, op_ready);
      end
      tick();
    end
    run_img(10'($urandom), 10'($urandom), 2, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sprite_ops();
    test_wait_vsync();
    test_put_image();
    test_collision();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/graphics_op_controller.md
Name: graphics_op_controller

Overview:
Execute-stage sequencer for the processor's programmable graphics functions.
- Accepts one decoded op at a time.
- Completes single-cycle ops in place; stalls the fetch/PC path (op_ready low) for multi-cycle ops.
- Multi-cycle ops are VSYNC waits and req/ack handshakes with the background writer and the collision unit.
- Owns the background_x/y and sprite_x/y/id/level registers that feed the video modules.

Parameters:
ACK_TIMEOUT, 255, cycles allowed for img_ack/col_ack before abandoning; 0 disables the timeout
COORD_WIDTH, 10, coordinate width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
op_valid  in  1  decoded op present
op_code  in  5  function code (matches processor FUNCTION_* values)
op_sprite_id  in  5  sprite index operand
op_x  in  COORD_WIDTH  x operand / level value (low 5 bits)
op_y  in  COORD_WIDTH  y operand
op_ready  out  1  op accepted this cycle; low = stall PC
vsync  in  1  level from video timing
img_req  out  1  put-image request
img_ack  in  1  put-image done
img_x  out  COORD_WIDTH  put-image x
img_y  out  COORD_WIDTH  put-image y
col_req  out  1  collision query request
col_kind  out  1  0 = vs background, 1 = vs sprite
col_sprite_id  out  5  queried sprite
col_ack  in  1  query done
col_hit  in  1  query result, valid with col_ack
background_x  out  COORD_WIDTH  background offset
background_y  out  COORD_WIDTH  background offset
sprite_x  out  COORD_WIDTH  last written sprite x
sprite_y  out  COORD_WIDTH  last written sprite y
sprite_id  out  5  last written sprite index
sprite_level  out  5  last written level
sprite_we  out  1  one-cycle pulse: sprite pos written
level_we  out  1  one-cycle pulse: level written
result_valid  out  1  one-cycle pulse: collision result
result  out  1  collision flag
timeout  out  1  one-cycle pulse: handshake abandoned

Behaviour:
Reset:
- All outputs 0; state IDLE; counter 0.
- vsync_q resets to 1 so vsync high at reset release is not an edge.

States and op_ready:
- States: IDLE, WAIT_VS, IMG_WAIT, COL_WAIT.
- op_ready = (state == IDLE), combinational.
- Accept = op_valid & op_ready.

Accept in IDLE, by op_code:
- SPRITE_POS (00010): next cycle sprite_x/y/id = operands, sprite_we=1 for one cycle; stay IDLE. Back-to-back accepts give back-to-back pulses.
- SPRITE_LEVEL (00001): sprite_id = op_sprite_id, sprite_level = op_x[4:0], level_we pulse; stay IDLE.
- PUT_IMAGE (00101): latch img_x/y; img_req=1 from the next cycle; go to IMG_WAIT.
- SPRITE_COLLISION_BG / SPRITE_COLLISION_SP (00011/00100): col_kind = 0/1, latch col_sprite_id, col_req=1; go to COL_WAIT.
- WAIT_VSYNC (00110): go to WAIT_VS.
- Any other code: consumed as NOP, no output change.

WAIT_VS:
- Edge = vsync & ~vsync_q (vsync_q is vsync registered every cycle).
- An edge in the accept cycle does not count.
- Return to IDLE the cycle after the first edge seen while in WAIT_VS.

IMG_WAIT:
- img_req held high until img_ack is sampled high.
- On ack: next cycle img_req=0, background_x/y = img_x/img_y, IDLE.
- An ack arriving before req is asserted is ignored.

COL_WAIT:
- col_req held high until col_ack.
- On ack: next cycle col_req=0, result = col_hit, result_valid=1 for one cycle, IDLE.

Timeout (IMG_WAIT/COL_WAIT, ACK_TIMEOUT > 0):
- Counter clears on entry and increments each waiting cycle.
- When the count reaches ACK_TIMEOUT with no ack: drop req; timeout pulse; IDLE.
- In COL_WAIT a timeout also gives result_valid=1, result=0.
- background_x/y unchanged on timeout.
- Ack in the same cycle as expiry: ack wins, no timeout pulse.

Reset mid-op:
- Aborts immediately; reqs low on the cycle after reset is sampled.
- No result_valid or timeout pulse.

Other rules:
- result holds its value until the next collision completes.
- Single-cycle pulse outputs never stretch.

Decomposition:
- Package graphics_op_pkg: the six opcode constants (shared with the processor decode), state encoding, COL_KIND_BG/SP.
- One sub-module, handshake_timer: clear/enable/expire counter parameterised by ACK_TIMEOUT, reused for both handshake waits.
- Edge detect and FSM stay inline.

Test Plan:
- SPRITE_POS id=3, x=100, y=50 then SPRITE_LEVEL id=3, level=7 on consecutive cycles -> sprite_we then level_we pulses; sprite_x=100, y=50, level=7; op_ready stays 1.
- WAIT_VSYNC with vsync already high at accept; vsync low 5 cycles then high -> op_ready low until the cycle after the rising edge, then 1.
- PUT_IMAGE x=320, y=240, img_ack after 4 cycles -> img_req high 4 cycles; background_x=320, y=240 next cycle; op_ready returns.
- SPRITE_COLLISION_SP id=9, col_ack with col_hit=1 after 2 cycles -> col_kind=1, col_sprite_id=9; result_valid pulse, result=1.
- ACK_TIMEOUT=8, COLLISION_BG with no ack -> col_req drops after 8 waiting cycles; timeout and result_valid pulse, result=0. Repeat with ack exactly at expiry -> no timeout pulse.
- Reset asserted mid IMG_WAIT -> img_req 0 next cycle, all outputs 0, state IDLE, background unchanged from reset value 0.
